// File: rtl/imem_loader_pkg.sv
// Shared types and framing constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_e;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, RAM write port and status lines of the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 14
);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  modport master (
    input  start, rx_data, rx_valid,
    output imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
  );

  modport slave (
    output start, rx_data, rx_valid,
    input  imem_we, imem_addr, imem_wdata, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/imem_word_packer.sv
// Shifts bytes MSB-first into a 32-bit word; word_ready pulses the cycle after
// the last byte of a word was accepted.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] word_out,
  output logic        word_ready
);
  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [31:0]      shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (clr) begin
        cnt_q <= '0;
      end else if (byte_valid) begin
        shreg_q <= {shreg_q[23:0], byte_in};
        cnt_q   <= cnt_q + CNT_W'(1);
        ready_q <= (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
      end
    end
  end

  assign word_out   = shreg_q;
  assign word_ready = ready_q;
endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream into instruction RAM while holding the CPU in reset.
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   LEN_HI | expecting word-count high byte
//   LEN_LO | expecting word-count low byte, range check
//   DATA   | packing data bytes, writing words
//   CSUM   | comparing checksum byte
//   DONE   | load verified, CPU released
//   ERR    | oversize, bad checksum or timeout, CPU released
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input logic             clock,
  input logic             reset,
  imem_loader_if.master   bus
);
  localparam int HDR_W = LEN_BYTES * 8;
  localparam int REM_W = HDR_W + $clog2(BYTES_PER_WORD);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_e            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              start_q;

  logic              pk_clr, pk_valid, pk_ready;
  logic [31:0]       pk_word;
  logic [HDR_W-1:0]  n_len;
  logic              active, start_rise, enter;

  assign n_len      = {len_hi_q, bus.rx_data};
  assign active     = (state_q inside {LEN_HI, LEN_LO, DATA, CSUM});
  assign start_rise = bus.start & ~start_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      len_hi_q <= '0;
      rem_q    <= '0;
      idx_q    <= '0;
      csum_q   <= '0;
      tmo_q    <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      tmo_q    <= tmo_d;
      start_q  <= bus.start;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    tmo_d    = '0;
    pk_clr   = 1'b0;
    pk_valid = 1'b0;
    enter    = 1'b0;

    if (active) tmo_d = bus.rx_valid ? '0 : tmo_q + TMO_W'(1);
    // Index saturates so a full-depth load never wraps back to 0.
    if (pk_ready && idx_q != '1) idx_d = idx_q + ADDR_W'(1);

    case (state_q)
      IDLE:      enter = bus.start;
      DONE, ERR: enter = start_rise;
      LEN_HI: if (bus.rx_valid) begin
        len_hi_d = bus.rx_data;
        state_d  = LEN_LO;
      end
      LEN_LO: if (bus.rx_valid) begin
        if (32'(n_len) > (32'd1 << ADDR_W)) state_d = ERR;
        else if (n_len == '0)               state_d = CSUM;
        else begin
          rem_d   = REM_W'(n_len) << $clog2(BYTES_PER_WORD);
          state_d = DATA;
        end
      end
      DATA: if (bus.rx_valid) begin
        pk_valid = 1'b1;
        csum_d   = csum_q + bus.rx_data;
        rem_d    = rem_q - REM_W'(1);
        if (rem_q == REM_W'(1)) state_d = CSUM;
      end
      CSUM: if (bus.rx_valid) state_d = (bus.rx_data == csum_q) ? DONE : ERR;
      default: state_d = IDLE;
    endcase

    if (active && !bus.rx_valid && tmo_q == TMO_W'(TIMEOUT_CYC - 1)) state_d = ERR;

    if (enter) begin
      state_d = LEN_HI;
      idx_d   = '0;
      csum_d  = '0;
      rem_d   = '0;
      pk_clr  = 1'b1;
    end
  end

  imem_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clr        (pk_clr),
    .byte_in    (bus.rx_data),
    .byte_valid (pk_valid),
    .word_out   (pk_word),
    .word_ready (pk_ready)
  );

  assign bus.imem_we    = pk_ready;
  assign bus.imem_addr  = idx_q;
  assign bus.imem_wdata = pk_word;
  assign bus.cpu_hold   = active;
  assign bus.load_done  = (state_q == DONE);
  assign bus.load_err   = (state_q == ERR);
endmodule

// File: tb/tb_imem_loader.sv
// Randomised frame bench for imem_loader with a queue-based write scoreboard.
module tb_imem_loader;
  localparam int AW    = 4;
  localparam int TMO   = 16;
  localparam int DEPTH = 1 << AW;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_cyc[$];
  logic [31:0] fw[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest expected write.
  always @(negedge clock) begin
    if (reset === 1'b0 && bus.imem_we === 1'b1) begin
      if (exp_addr.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        chk("wr_addr", 64'(bus.imem_addr), 64'(exp_addr.pop_front()));
        chk("wr_data", 64'(bus.imem_wdata), 64'(exp_data.pop_front()));
        chk("wr_cycle", 64'(cyc), 64'(exp_cyc.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

  // Called #1 after a posedge; returns #1 after the edge that captured the byte.
  task automatic drive_byte(input logic [7:0] b, input int gap, output int t);
    repeat (gap) begin @(posedge clock); #1; end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    t = cyc;
    @(posedge clock); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic fill_random(input int n);
    fw.delete();
    for (int i = 0; i < n; i++) fw.push_back($urandom);
  endtask

  // csum_sel: -1 correct checksum, -2 random wrong checksum, else literal byte.
  task automatic run_frame(input int n, input int csum_sel, input int maxgap, input bit hold_start);
    logic [7:0]  sum, cs, b;
    logic [31:0] w;
    int          t;
    bit          ok;
    sum = 8'h00;
    bus.start = 1'b1;
    @(posedge clock); #1;
    if (!hold_start) bus.start = 1'b0;
    drive_byte(8'(n >> 8), $urandom_range(0, maxgap), t);
    chk("hold_in_load", 64'(bus.cpu_hold), 64'd1);
    drive_byte(8'(n), $urandom_range(0, maxgap), t);
    if (n > DEPTH) begin
      chk("oversize_err", 64'(bus.load_err), 64'd1);
      chk("oversize_done", 64'(bus.load_done), 64'd0);
      chk("oversize_hold", 64'(bus.cpu_hold), 64'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = fw[i];
      for (int k = 0; k < 4; k++) begin
        b = w[31 - 8*k -: 8];
        sum = sum + b;
        drive_byte(b, $urandom_range(0, maxgap), t);
        if (k == 3) begin
          exp_addr.push_back(i);
          exp_data.push_back(w);
          exp_cyc.push_back(t + 1);
        end
      end
    end
    if (csum_sel == -1)      cs = sum;
    else if (csum_sel == -2) cs = sum ^ 8'($urandom_range(1, 255));
    else                     cs = 8'(csum_sel);
    ok = (cs == sum);
    drive_byte(cs, $urandom_range(0, maxgap), t);
    chk("pending_writes", 64'(exp_addr.size()), 64'd0);
    chk("load_done", 64'(bus.load_done), 64'(ok));
    chk("load_err", 64'(bus.load_err), 64'(!ok));
    chk("hold_released", 64'(bus.cpu_hold), 64'd0);
  endtask

  initial begin
    int t;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #2;
    chk("rst_we", 64'(bus.imem_we), 64'd0);
    chk("rst_hold", 64'(bus.cpu_hold), 64'd0);
    chk("rst_done", 64'(bus.load_done), 64'd0);
    chk("rst_err", 64'(bus.load_err), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    #20 reset = 1'b0;
    @(posedge clock); #1;

    // Nominal two-word frame, back-to-back bytes; data sum is 0x38.
    fw = '{32'h12345678, 32'h9ABCDEF0};
    run_frame(2, -1, 0, 0);

    run_frame(2, 8'h29, 0, 0);

    fw.delete();
    run_frame(0, -1, 0, 0);

    run_frame(17, -1, 0, 0);

    // Timeout: ERR lands on the 16th idle edge after the AA byte.
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    drive_byte(8'h00, 0, t);
    drive_byte(8'h01, 0, t);
    drive_byte(8'hAA, 0, t);
    repeat (15) @(posedge clock);
    #1;
    chk("tmo_not_yet", 64'(bus.load_err), 64'd0);
    chk("tmo_hold", 64'(bus.cpu_hold), 64'd1);
    @(posedge clock); #1;
    chk("tmo_err", 64'(bus.load_err), 64'd1);
    chk("tmo_hold_rel", 64'(bus.cpu_hold), 64'd0);

    // Reset after the third byte of word 0.
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    drive_byte(8'h00, 0, t);
    drive_byte(8'h01, 0, t);
    drive_byte(8'h11, 0, t);
    drive_byte(8'h22, 0, t);
    drive_byte(8'h33, 0, t);
    #3 reset = 1'b1;
    #1;
    chk("midrst_hold", 64'(bus.cpu_hold), 64'd0);
    chk("midrst_we", 64'(bus.imem_we), 64'd0);
    chk("midrst_done", 64'(bus.load_done), 64'd0);
    chk("midrst_err", 64'(bus.load_err), 64'd0);
    #10 reset = 1'b0;
    @(posedge clock); #1;
    fw = '{32'h12345678, 32'h9ABCDEF0};
    run_frame(2, -1, 0, 0);

    // Level-held start must not relaunch; bytes after DONE are dropped.
    fill_random(3);
    run_frame(3, -1, 2, 1);
    repeat (6) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) drive_byte(8'($urandom), 0, t);
    repeat (3) @(posedge clock);
    #1;
    chk("held_start_done", 64'(bus.load_done), 64'd1);
    chk("held_start_hold", 64'(bus.cpu_hold), 64'd0);
    bus.start = 1'b0;
    @(posedge clock); #1;

    for (int f = 0; f < 10; f++) begin
      int n;
      n = (f == 0) ? DEPTH : $urandom_range(1, DEPTH);
      fill_random(n);
      run_frame(n, ($urandom_range(0, 3) == 0) ? -2 : -1, 3, 0);
    end

    repeat (4) @(posedge clock);
    #1;
    chk("final_pending", 64'(exp_addr.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
